// File: rtl/norm_sched.sv
// Round-robin, credit-based scheduler sharing one fixed-latency norm pipeline between requesters.
// Define NORM_SCHED_CHECK_EN to add a latency/ID consistency checker that also drives err.
module norm_sched #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned TAG_W      = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned NORM_LAT   = 43,
   localparam int unsigned IDX_W     = $clog2(NUM_REQ),
   localparam int unsigned ID_W      = IDX_W + TAG_W
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*32-1:0]    req_dot_sum,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     n_valid_in,
   output logic [31:0]              n_dot_sum,
   output logic [ID_W-1:0]          n_vec_id,
   input  logic                     n_valid_out,
   input  logic [31:0]              n_inv_sqrt,
   input  logic [ID_W-1:0]          n_id,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [31:0]              res_data,
   output logic [IDX_W-1:0]         res_idx,
   output logic [TAG_W-1:0]         res_tag,
   input  logic                     drain,
   output logic                     drain_done,
   output logic                     busy,
   output logic                     err
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 32 + ID_W;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   reserved_q, reserved_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic               n_valid_in_q, n_valid_in_d;
   logic [31:0]        n_dot_sum_q, n_dot_sum_d;
   logic [ID_W-1:0]    n_vec_id_q, n_vec_id_d;
   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               drain_seen_q, drain_seen_d;
   logic               drain_done_q, drain_done_d;
   logic               err_q, err_d;
`ifdef NORM_SCHED_CHECK_EN
   logic [NORM_LAT-1:0] vpipe_q, vpipe_d;
`endif

   logic [NUM_REQ-1:0] cand, grant;
   logic [IDX_W-1:0]   win_idx, pos;
   logic               xfer, pop, full, wr;

   // Round-robin search starting just after the last winner.
   always_comb begin
      cand = '0;
      if (reserved_q < CNT_W'(FIFO_DEPTH) && !drain && state_q != StDrain) cand = req_valid;
      grant   = '0;
      win_idx = '0;
      pos     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         pos = IDX_W'((32'(last_q) + 32'd1 + k) % NUM_REQ);
         if (grant == '0 && cand[pos]) begin
            grant[pos] = 1'b1;
            win_idx    = pos;
         end
      end
   end

   assign xfer = |grant;
   assign pop  = (count_q != '0) && res_ready;
   assign full = count_q == CNT_W'(FIFO_DEPTH);
   assign wr   = n_valid_out && !full;

   always_comb begin
      reserved_d   = reserved_q + CNT_W'(xfer) - CNT_W'(pop);
      last_d       = xfer ? win_idx : last_q;
      n_valid_in_d = xfer;
      n_dot_sum_d  = xfer ? req_dot_sum[32*32'(win_idx) +: 32] : n_dot_sum_q;
      n_vec_id_d   = xfer ? {win_idx, req_tag[TAG_W*32'(win_idx) +: TAG_W]} : n_vec_id_q;

      mem_d = mem_q;
      if (wr) mem_d[wr_ptr_q] = {n_inv_sqrt, n_id};
      wr_ptr_d = wr_ptr_q + PTR_W'(wr);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(wr) - CNT_W'(pop);

      // Overflow is only reachable if norm produces results nobody reserved.
      err_d = err_q | (n_valid_out && full);
`ifdef NORM_SCHED_CHECK_EN
      vpipe_d = {vpipe_q[NORM_LAT-2:0], n_valid_in_q};
      if (vpipe_q[NORM_LAT-1] != n_valid_out) err_d = 1'b1;
      if (n_valid_out && (32'(n_id[ID_W-1 -: IDX_W]) >= NUM_REQ)) err_d = 1'b1;
`endif

      state_d      = state_q;
      drain_done_d = 1'b0;
      // A completed drain is not re-armed until drain drops.
      drain_seen_d = drain_seen_q && drain;
      unique case (state_q)
         StIdle: begin
            if (drain && !drain_seen_q) state_d = StDrain;
            else if (xfer)              state_d = StRun;
         end
         StRun: begin
            if (drain)                             state_d = StDrain;
            else if (reserved_q == '0 && !xfer)    state_d = StIdle;
         end
         StDrain: begin
            if (reserved_q == '0) begin
               state_d      = StIdle;
               drain_done_d = 1'b1;
               drain_seen_d = drain;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= StIdle;
         reserved_q   <= '0;
         last_q       <= IDX_W'(NUM_REQ - 1);
         n_valid_in_q <= 1'b0;
         n_dot_sum_q  <= '0;
         n_vec_id_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drain_seen_q <= 1'b0;
         drain_done_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef NORM_SCHED_CHECK_EN
         vpipe_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         reserved_q   <= reserved_d;
         last_q       <= last_d;
         n_valid_in_q <= n_valid_in_d;
         n_dot_sum_q  <= n_dot_sum_d;
         n_vec_id_q   <= n_vec_id_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drain_seen_q <= drain_seen_d;
         drain_done_q <= drain_done_d;
         err_q        <= err_d;
`ifdef NORM_SCHED_CHECK_EN
         vpipe_q      <= vpipe_d;
`endif
      end
   end

   assign req_ready  = grant;
   assign n_valid_in = n_valid_in_q;
   assign n_dot_sum  = n_dot_sum_q;
   assign n_vec_id   = n_vec_id_q;
   assign res_valid  = count_q != '0;
   assign {res_data, res_idx, res_tag} = mem_q[rd_ptr_q];
   assign drain_done = drain_done_q;
   assign busy       = reserved_q != '0;
   assign err        = err_q;

endmodule
